// File: rtl/ysyx_22041461_mc_ctrl.sv
// rtl/ysyx_22041461_mc_ctrl.sv - multi-cycle core control FSM
// Purpose: sequences fetch, execute, data-memory access and writeback for a
//   multi-cycle core, with a per-handshake wait timeout, a sticky halt on
//   ebreak and a retired-instruction counter.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req_*, if_resp_*            instruction fetch request/response
//   inst                           latched instruction to the decoder
//   dec_*                          decoder results for the current inst
//   next_pc                        datapath next-pc (snpc or target)
//   ls_req_*, ls_we, ls_resp_valid data-memory request/response
//   reg_we, commit                 writeback strobe, one-cycle retire pulse
//   pc, instret                    architectural pc, retired count
//   halt, timeout                  sticky ebreak / handshake-timeout flags
module ysyx_22041461_mc_ctrl #(
  parameter int               XLEN     = 64,
  parameter logic [XLEN-1:0]  RESET_PC = 64'h8000_0000,
  parameter int               MAX_WAIT = 255
) (
  input  logic            clk,
  input  logic            rst,
  output logic            if_req_valid,
  input  logic            if_req_ready,
  output logic [XLEN-1:0] if_req_addr,
  input  logic            if_resp_valid,
  input  logic [31:0]     if_resp_inst,
  output logic [31:0]     inst,
  input  logic            dec_is_load,
  input  logic            dec_is_store,
  input  logic            dec_rd_we,
  input  logic            dec_ebreak,
  input  logic [XLEN-1:0] next_pc,
  output logic            ls_req_valid,
  input  logic            ls_req_ready,
  output logic            ls_we,
  input  logic            ls_resp_valid,
  output logic            reg_we,
  output logic [XLEN-1:0] pc,
  output logic            commit,
  output logic [63:0]     instret,
  output logic            halt,
  output logic            timeout
);

  typedef enum logic [3:0] {
    IDLE, IF_REQ, IF_WAIT, EX, MEM_REQ, MEM_WAIT, WB, HALT, ERR
  } state_t;

  localparam logic [16:0] WAIT_LIM = 17'(MAX_WAIT);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] npc_q, npc_d;
  logic [31:0]     inst_q, inst_d;
  logic [63:0]     instret_q, instret_d;
  logic [15:0]     wait_q, wait_d;
  logic            halt_ack_q, halt_ack_d;
  logic [16:0]     wait_inc;
  logic            wait_hit;

  // The counter is one wider than needed so the compare never wraps.
  assign wait_inc = {1'b0, wait_q} + 17'd1;
  assign wait_hit = (wait_inc == WAIT_LIM);

  assign if_req_addr = pc_q;
  assign pc          = pc_q;
  assign inst        = inst_q;
  assign instret     = instret_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    npc_d        = npc_q;
    inst_d       = inst_q;
    instret_d    = instret_q;
    halt_ack_d   = halt_ack_q;
    // Any transition lands with a zeroed counter; staying in a wait state
    // overrides this with the incremented value.
    wait_d       = '0;
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    ls_we        = 1'b0;
    reg_we       = 1'b0;
    commit       = 1'b0;
    halt         = 1'b0;
    timeout      = 1'b0;
    case (state_q)
      IDLE: state_d = IF_REQ;
      IF_REQ: begin
        if_req_valid = 1'b1;
        if (if_req_ready)  state_d = IF_WAIT;
        else if (wait_hit) state_d = ERR;
        else               wait_d  = wait_inc[15:0];
      end
      IF_WAIT: begin
        if (if_resp_valid) begin
          inst_d  = if_resp_inst;
          state_d = EX;
        end else if (wait_hit) begin
          state_d = ERR;
        end else begin
          wait_d = wait_inc[15:0];
        end
      end
      EX: begin
        npc_d = next_pc;
        if (dec_ebreak) begin
          // ebreak retires on entry to HALT rather than through WB.
          instret_d = instret_q + 64'd1;
          state_d   = HALT;
        end else if (dec_is_load || dec_is_store) begin
          state_d = MEM_REQ;
        end else begin
          state_d = WB;
        end
      end
      MEM_REQ: begin
        ls_req_valid = 1'b1;
        ls_we        = dec_is_store;
        if (ls_req_ready)  state_d = MEM_WAIT;
        else if (wait_hit) state_d = ERR;
        else               wait_d  = wait_inc[15:0];
      end
      MEM_WAIT: begin
        if (ls_resp_valid) state_d = WB;
        else if (wait_hit) state_d = ERR;
        else               wait_d  = wait_inc[15:0];
      end
      WB: begin
        reg_we    = dec_rd_we && !dec_is_store;
        commit    = 1'b1;
        pc_d      = npc_q;
        instret_d = instret_q + 64'd1;
        state_d   = IF_REQ;
      end
      HALT: begin
        halt       = 1'b1;
        // halt_ack_q limits the retire pulse to the first HALT cycle.
        commit     = !halt_ack_q;
        halt_ack_d = 1'b1;
      end
      ERR: timeout = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      npc_q      <= RESET_PC;
      inst_q     <= '0;
      instret_q  <= '0;
      wait_q     <= '0;
      halt_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      inst_q     <= inst_d;
      instret_q  <= instret_d;
      wait_q     <= wait_d;
      halt_ack_q <= halt_ack_d;
    end
  end

endmodule

// File: doc/ysyx_22041461_mc_ctrl.md
YSYX_22041461_MC_CTRL -- requirements
Module: ysyx_22041461_mc_ctrl

Interface
REQ-001 Parameters SHALL be: XLEN, default 64, datapath/address width; RESET_PC, default 64'h8000_0000, first fetch address; MAX_WAIT, default 255, handshake timeout in cycles (1..65535).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, clock and reset first:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  synchronous active-high reset
- if_req_valid  out  1  fetch request
- if_req_ready  in  1  fetch accept
- if_req_addr  out  XLEN  fetch address (= pc)
- if_resp_valid  in  1  fetch data valid
- if_resp_inst  in  32  fetched instruction
- inst  out  32  latched instruction to decoder
- dec_is_load  in  1  decoded load
- dec_is_store  in  1  decoded store
- dec_rd_we  in  1  instruction writes rd
- dec_ebreak  in  1  decoded ebreak
- next_pc  in  XLEN  datapath next-pc (snpc or branch/jump target)
- ls_req_valid  out  1  data-memory request
- ls_req_ready  in  1  data-memory accept
- ls_we  out  1  1 = store, 0 = load; valid with ls_req_valid
- ls_resp_valid  in  1  load data valid / store done
- reg_we  out  1  register-file write strobe
- pc  out  XLEN  architectural pc
- commit  out  1  one-cycle retire pulse
- instret  out  64  retired-instruction count
- halt  out  1  sticky, ebreak retired
- timeout  out  1  sticky, handshake timeout

Function
REQ-004 FSM states SHALL be IDLE, IF_REQ, IF_WAIT, EX, MEM_REQ, MEM_WAIT, WB, HALT, ERR.
REQ-005 IDLE SHALL go to IF_REQ unconditionally on the next cycle.
REQ-006 IF_REQ: if_req_valid=1; on if_req_ready=1 -> IF_WAIT.
REQ-007 if_req_valid and if_req_addr SHALL stay stable until accepted.
REQ-008 IF_WAIT: on if_resp_valid=1, latch if_resp_inst into inst -> EX.
REQ-009 if_resp_valid SHALL be ignored outside IF_WAIT.
REQ-010 EX: latch next_pc.
- dec_ebreak=1 -> HALT (ebreak takes priority).
- else load or store -> MEM_REQ.
- else -> WB.
REQ-011 MEM_REQ: ls_req_valid=1, ls_we=dec_is_store; on ls_req_ready=1 -> MEM_WAIT.
REQ-012 MEM_WAIT: on ls_resp_valid=1 -> WB; ls_resp_valid SHALL be ignored in all other states.
REQ-013 WB, for exactly one cycle:
- reg_we = dec_rd_we AND NOT dec_is_store;
- pc <= latched next_pc;
- commit=1;
- instret += 1, wrapping at 2^64;
- -> IF_REQ.
REQ-014 Latency SHALL be 4 cycles per non-memory instruction and 6 per load/store, both with zero-wait memory (ready=1, response one cycle after accept).
REQ-015 HALT: halt=1, commit=1 for the entry cycle only, instret += 1; no further requests; absorbing until rst.
REQ-016 Wait counter:
- cleared on entry to IF_REQ, IF_WAIT, MEM_REQ and MEM_WAIT;
- increments each cycle spent in those states;
- reaching MAX_WAIT -> ERR.
REQ-017 ERR: timeout=1; no requests, no commits; absorbing until rst.
REQ-018 reg_we, commit, if_req_valid and ls_req_valid SHALL be 0 in every state not named above for them.
REQ-019 pc SHALL update only in WB; an XLEN-bit next_pc wraps naturally, with no alignment check.

Reset
REQ-020 Reset SHALL apply in any state, including mid-handshake, and take effect at the next edge.
REQ-021 Values on the cycle after rst is sampled high:
- state=IDLE, pc=RESET_PC, inst=0, instret=0;
- halt=0, timeout=0, wait counter=0;
- all request and strobe outputs 0.
REQ-022 Responses still outstanding at reset SHALL be discarded, because IDLE and IF_REQ ignore them.

Verification
REQ-023 ALU op (addi), zero-wait memory -> if_req_valid at cycle 1 after reset release with addr 0x80000000; commit at cycle 4; pc=0x80000004; instret=1; reg_we=1 with commit.
REQ-024 Load then store, zero-wait -> each commits 6 cycles apart; ls_we=0 for the load, 1 for the store; reg_we=1 on the load only; instret=2.
REQ-025 if_req_ready held low 10 cycles, then high -> if_req_valid and if_req_addr stable for all 11 cycles; commit delayed by exactly 10 cycles.
REQ-026 ebreak fetched -> halt=1 and instret+1 in the cycle after EX; no if_req_valid thereafter for 100 cycles.
REQ-027 MAX_WAIT=8, if_resp_valid never asserted -> timeout=1 after 8 cycles in IF_WAIT; no commit; rst clears timeout and restarts fetch at RESET_PC.
REQ-028 rst pulsed in MEM_WAIT, then stale ls_resp_valid -> no reg_we or commit; refetch from RESET_PC; instret=0.
